// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM block and its duty-cycle sources.
// Duty values are signed 32-bit percentages in 0..DUTY_MAX.
package pwm_pkg;
  localparam int DUTY_W = 32;
  localparam int DUTY_MAX = 100;

  typedef logic signed [DUTY_W-1:0] duty_t;

  localparam int CLK_FREQ_DEFAULT = 33_330_000;
  localparam int PWM_FREQ_DEFAULT = 500_000;
endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table q[0..TABLE_SIZE/4], scaled to AMPLITUDE.
// Contents are fixed at elaboration; the lookup is purely combinational.
module sine_quarter_rom
  import pwm_pkg::*;
#(
  parameter int AMPLITUDE  = 50,
  parameter int TABLE_SIZE = 64
) (
  input  logic [$clog2(TABLE_SIZE)-2:0] idx,
  output duty_t                         q
);
  localparam int QN = TABLE_SIZE / 4 + 1;
  localparam int AW = $clog2(TABLE_SIZE) - 1;
  localparam real PI = 3.14159265358979323846;

  function automatic int qval(input int i);
    real a;
    a = AMPLITUDE * $sin(2.0 * PI * i / TABLE_SIZE);
    return $rtoi(a + 0.5);
  endfunction

  duty_t tab [QN];

  for (genvar g = 0; g < QN; g++) begin : g_q
    localparam int V = qval(g);
    assign tab[g] = duty_t'(V);
  end

  always_comb begin
    q = '0;
    for (int i = 0; i < QN; i++) begin
      if (idx == AW'(i)) q = tab[i];
    end
  end
endmodule

// File: rtl/sine_duty_gen.sv
// Steps a sine table at a fixed sample rate and hands each new duty
// value to the PWM only on a carrier-period boundary.
module sine_duty_gen
  import pwm_pkg::*;
#(
  parameter int CLK_FREQUENCY  = CLK_FREQ_DEFAULT,
  parameter int PWM_FREQUENCY  = PWM_FREQ_DEFAULT,
  parameter int SINE_FREQUENCY = 310,
  parameter int TABLE_SIZE     = 64,
  parameter int AMPLITUDE      = 50,
  parameter int OFFSET         = 50
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output duty_t                         duty_cycle,
  output logic                          duty_update,
  output logic [$clog2(TABLE_SIZE)-1:0] phase_idx,
  output logic                          zero_cross
);
  localparam int STEPS = CLK_FREQUENCY / PWM_FREQUENCY;
  localparam int SAMPLE_DIV =
    CLK_FREQUENCY / (SINE_FREQUENCY * TABLE_SIZE);
  localparam int IW = $clog2(TABLE_SIZE);
  localparam int QW = IW - 1;
  localparam int PW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  if (SAMPLE_DIV < STEPS) begin : g_err_div
    $error("SAMPLE_DIV must be >= STEPS");
  end
  if (STEPS < 2) begin : g_err_steps
    $error("STEPS must be >= 2");
  end
  if (OFFSET - AMPLITUDE < 0) begin : g_err_lo
    $error("OFFSET-AMPLITUDE must be >= 0");
  end
  if (OFFSET + AMPLITUDE > DUTY_MAX) begin : g_err_hi
    $error("OFFSET+AMPLITUDE must be <= 100");
  end
  if ((TABLE_SIZE & (TABLE_SIZE - 1)) != 0 || TABLE_SIZE < 8)
  begin : g_err_tbl
    $error("TABLE_SIZE must be a power of two >= 8");
  end

  logic [PW-1:0] period_cnt;
  logic [SW-1:0] sample_cnt;
  logic          pending;
  logic          boundary;
  logic          tick;
  logic          consume;

  assign boundary = (period_cnt == PW'(STEPS - 1));
  assign tick     = (sample_cnt == SW'(SAMPLE_DIV - 1));
  assign consume  = boundary && (pending || tick);

  // Fold the next index onto the quarter table; quad[1] selects the sign.
  logic [IW-1:0] nidx;
  logic [1:0]    quad;
  logic [QW-1:0] low;
  logic [QW-1:0] addr;
  duty_t         qv;
  duty_t         nxt_duty;

  assign nidx = phase_idx + IW'(1);
  assign quad = nidx[IW-1 -: 2];
  assign low  = {1'b0, nidx[IW-3:0]};
  assign addr = quad[0] ? (QW'(TABLE_SIZE / 4) - low) : low;

  sine_quarter_rom #(
    .AMPLITUDE (AMPLITUDE),
    .TABLE_SIZE(TABLE_SIZE)
  ) u_rom (
    .idx(addr),
    .q  (qv)
  );

  assign nxt_duty = duty_t'(OFFSET) + (quad[1] ? -qv : qv);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      period_cnt  <= '0;
      sample_cnt  <= '0;
      pending     <= 1'b0;
      phase_idx   <= '0;
      duty_cycle  <= duty_t'(OFFSET);
      duty_update <= 1'b0;
      zero_cross  <= 1'b0;
    end else begin
      period_cnt  <= boundary ? '0 : period_cnt + PW'(1);
      sample_cnt  <= tick ? '0 : sample_cnt + SW'(1);
      duty_update <= 1'b0;
      zero_cross  <= 1'b0;
      if (consume) begin
        phase_idx   <= nidx;
        duty_cycle  <= nxt_duty;
        duty_update <= 1'b1;
        zero_cross  <= (nidx == '0);
        pending     <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sine_duty_gen.sv
// Bench for sine_duty_gen: directed scenarios plus random rst/en
// traffic, checked every cycle against a tick/update count model.
module tb_sine_duty_gen;
  import pwm_pkg::*;

  localparam int CF  = 6400;
  localparam int PF  = 1600;
  localparam int SF  = 10;
  localparam int TS  = 64;
  localparam int AMP = 50;
  localparam int OFS = 50;
  localparam int ST  = CF / PF;
  localparam int SD  = CF / (SF * TS);
  localparam int IW  = $clog2(TS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  duty_t         duty_cycle;
  logic          duty_update;
  logic [IW-1:0] phase_idx;
  logic          zero_cross;

  int checks = 0;
  int failures = 0;
  int sine_tab [TS];
  int t = 0;
  int upd = 0;
  bit pulse = 1'b0;

  always #5 clk = ~clk;

  sine_duty_gen #(
    .CLK_FREQUENCY (CF),
    .PWM_FREQUENCY (PF),
    .SINE_FREQUENCY(SF),
    .TABLE_SIZE    (TS),
    .AMPLITUDE     (AMP),
    .OFFSET        (OFS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .duty_cycle (duty_cycle),
    .duty_update(duty_update),
    .phase_idx  (phase_idx),
    .zero_cross (zero_cross)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: one update per boundary whenever ticks seen exceed updates.
  task automatic step(input bit r, input bit e);
    int ticks;
    rst = r;
    en  = e;
    @(posedge clk);
    if (r || !e) begin
      t = 0;
      upd = 0;
      pulse = 1'b0;
    end else begin
      ticks = (t + 1) / SD;
      pulse = 1'b0;
      if ((t % ST) == ST - 1 && ticks > upd) begin
        upd++;
        pulse = 1'b1;
      end
      t++;
    end
    @(negedge clk);
    chk("duty", int'(duty_cycle), OFS + sine_tab[upd % TS]);
    chk("phase", int'(phase_idx), upd % TS);
    chk("update", int'(duty_update), int'(pulse));
    chk("zero_cross", int'(zero_cross),
        int'(pulse && (upd % TS) == 0));
  endtask

  initial begin
    real x;
    int first, first_duty, nupd, nzc;
    int d16, d32, d48;
    int du_hist [32];
    int off;
    bit e;

    for (int k = 0; k < TS; k++) begin
      x = AMP * $sin(2.0 * 3.14159265358979323846 * k / TS);
      sine_tab[k] = (x < 0.0) ? -$rtoi(-x + 0.5) : $rtoi(x + 0.5);
    end

    @(negedge clk);
    repeat (5) step(1'b1, 1'b1);
    chk("rst_duty", int'(duty_cycle), 50);

    first = 0; first_duty = 0; nupd = 0; nzc = 0;
    d16 = -1; d32 = -1; d48 = -1;
    for (int n = 1; n <= 800 && nupd < 64; n++) begin
      step(1'b0, 1'b1);
      if (n <= 32) du_hist[n-1] = int'(duty_update);
      if (duty_update) begin
        nupd++;
        if (first == 0) begin
          first = n;
          first_duty = int'(duty_cycle);
        end
        if (phase_idx == 16) d16 = int'(duty_cycle);
        if (phase_idx == 32) d32 = int'(duty_cycle);
        if (phase_idx == 48) d48 = int'(duty_cycle);
      end
      if (zero_cross) nzc++;
    end
    chk("first_cycle", first, 12);
    chk("first_duty", first_duty, 55);
    chk("tick_boundary", du_hist[19], 1);
    chk("no_dup", du_hist[23], 0);
    chk("upd_count", nupd, 64);
    chk("duty_k16", d16, 100);
    chk("duty_k32", d32, 50);
    chk("duty_k48", d48, 0);
    chk("zc_count", nzc, 1);
    chk("wrap_phase", int'(phase_idx), 0);
    chk("wrap_duty", int'(duty_cycle), 50);

    step(1'b1, 1'b1);
    for (int n = 0; n < 300 && t < 210; n++) step(1'b0, 1'b1);
    chk("pre_dis_phase", int'(phase_idx), 20);
    repeat (3) step(1'b0, 1'b0);
    chk("dis_duty", int'(duty_cycle), 50);
    chk("dis_phase", int'(phase_idx), 0);
    first = 0; first_duty = 0;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      step(1'b0, 1'b1);
      if (duty_update) begin
        first = n;
        first_duty = int'(duty_cycle);
      end
    end
    chk("reen_cycle", first, 12);
    chk("reen_duty", first_duty, 55);

    off = 0;
    for (int i = 0; i < 2000; i++) begin
      if (off > 0) begin
        off--;
        e = 1'b0;
      end else if ($urandom_range(99) == 0) begin
        off = $urandom_range(4);
        e = 1'b0;
      end else begin
        e = 1'b1;
      end
      step($urandom_range(199) == 0, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
